// File: rtl/dram_responder_pkg.sv
// dram_responder_pkg -- shared memory-port constants, responder state encoding and store-lane helpers.
// Rev 1.0
`default_nettype none

package dram_responder_pkg;

  localparam int XLEN         = 32;
  localparam int MEM_OP_WIDTH = 3;

  localparam logic [MEM_OP_WIDTH-1:0] MEM_OP_BYTE = 3'b001;
  localparam logic [MEM_OP_WIDTH-1:0] MEM_OP_HALF = 3'b010;
  localparam logic [MEM_OP_WIDTH-1:0] MEM_OP_WORD = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_READ = 2'd2
  } dram_state_e;

  // Byte-lane strobes for a store of the given size at the given lane offset.
  function automatic logic [XLEN/8-1:0] store_strobe(
    input logic [MEM_OP_WIDTH-1:0] op,
    input logic [1:0]              lane
  );
    logic [XLEN/8-1:0] s;
    s = '0;
    case (op)
      MEM_OP_BYTE: s = 4'b0001 << lane;
      MEM_OP_HALF: s = 4'b0011 << {lane[1], 1'b0};
      MEM_OP_WORD: s = 4'b1111;
      default:     s = '0;
    endcase
    return s;
  endfunction

  function automatic logic [XLEN-1:0] store_replicate(
    input logic [MEM_OP_WIDTH-1:0] op,
    input logic [XLEN-1:0]         data
  );
    logic [XLEN-1:0] r;
    r = data;
    case (op)
      MEM_OP_BYTE: r = {4{data[7:0]}};
      MEM_OP_HALF: r = {2{data[15:0]}};
      default:     r = data;
    endcase
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dram_store_align.sv
// dram_store_align -- combinational store lane alignment, strobes and misalign detection.
// Optional: DRAM_MISALIGN_CHECK_EN enables misalign detection and strobe suppression. Rev 1.0
`default_nettype none

module dram_store_align
  import dram_responder_pkg::*;
(
  input  logic [MEM_OP_WIDTH-1:0] opcode,
  input  logic [1:0]              addr_lo,
  input  logic [XLEN-1:0]         wdata,
  output logic [XLEN/8-1:0]       strobe,
  output logic [XLEN-1:0]         aligned_wdata,
  output logic                    misalign
);

`ifdef DRAM_MISALIGN_CHECK_EN
  assign misalign = ((opcode == MEM_OP_HALF) && addr_lo[0]) ||
                    ((opcode == MEM_OP_WORD) && (addr_lo != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  // A misaligned store must not touch memory at all.
  assign strobe        = misalign ? '0 : store_strobe(opcode, addr_lo);
  assign aligned_wdata = store_replicate(opcode, wdata);

endmodule

`default_nettype wire

// File: rtl/dram_responder.sv
// dram_responder -- data-RAM responder: one outstanding load/store, programmable wait states, SRAM drive.
// Optional: DRAM_MISALIGN_CHECK_EN (see dram_store_align). Rev 1.0
`default_nettype none

module dram_responder
  import dram_responder_pkg::*;
#(
  parameter int WAIT_CYCLES = 0,
  parameter int SRAM_AW     = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    dram_req,
  input  logic                    dram_write,
  input  logic [MEM_OP_WIDTH-1:0] dram_opcode,
  input  logic [XLEN-1:0]         dram_addr,
  input  logic [XLEN-1:0]         dram_wdata,
  input  logic                    dram_flush,
  output logic                    dram_addr_ok,
  output logic                    dram_data_ok,
  output logic [XLEN-1:0]         dram_rdata,
  output logic                    dram_misalign,
  output logic                    sram_en,
  output logic [XLEN/8-1:0]       sram_we,
  output logic [SRAM_AW-1:0]      sram_addr,
  output logic [XLEN-1:0]         sram_wdata,
  input  logic [XLEN-1:0]         sram_rdata
);

  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  dram_state_e state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;

  logic                    hold_write;
  logic [MEM_OP_WIDTH-1:0] hold_op;
  logic [SRAM_AW+1:0]      hold_addr;
  logic [XLEN-1:0]         hold_wdata;
  logic                    rd_misalign;

  logic                    accept;
  logic                    access;
  logic                    from_req;
  logic                    src_write;
  logic [MEM_OP_WIDTH-1:0] src_op;
  logic [SRAM_AW+1:0]      src_addr;
  logic [XLEN-1:0]         src_wdata;
  logic [XLEN/8-1:0]       strobe;
  logic [XLEN-1:0]         aligned_wdata;
  logic                    misalign;
  logic                    addr_hi_unused;

  assign addr_hi_unused = ^dram_addr[XLEN-1:SRAM_AW+2];

  assign dram_addr_ok = (state == S_IDLE) && !dram_flush && !rst;
  assign accept       = dram_req && dram_addr_ok;

  // In IDLE the SRAM can only be driven by a zero-wait accept, so the live request is the source.
  assign from_req  = (state == S_IDLE);
  assign src_write = from_req ? dram_write             : hold_write;
  assign src_op    = from_req ? dram_opcode            : hold_op;
  assign src_addr  = from_req ? dram_addr[SRAM_AW+1:0] : hold_addr;
  assign src_wdata = from_req ? dram_wdata             : hold_wdata;

  dram_store_align u_align (
    .opcode        (src_op),
    .addr_lo       (src_addr[1:0]),
    .wdata         (src_wdata),
    .strobe        (strobe),
    .aligned_wdata (aligned_wdata),
    .misalign      (misalign)
  );

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    access   = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            access   = 1'b1;
            state_nx = dram_write ? S_IDLE : S_READ;
          end else begin
            state_nx = S_WAIT;
            cnt_nx   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        // A flushed load is abandoned; an accepted store always commits.
        if (!hold_write && dram_flush) begin
          state_nx = S_IDLE;
        end else if (cnt == '0) begin
          access   = 1'b1;
          state_nx = hold_write ? S_IDLE : S_READ;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      S_READ: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      rd_misalign <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      rd_misalign <= access && !src_write && misalign;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      hold_write <= dram_write;
      hold_op    <= dram_opcode;
      hold_addr  <= dram_addr[SRAM_AW+1:0];
      hold_wdata <= dram_wdata;
    end
  end

  assign sram_en       = access && !rst;
  assign sram_we       = (sram_en && src_write) ? strobe : '0;
  assign sram_addr     = src_addr[SRAM_AW+1:2];
  assign sram_wdata    = aligned_wdata;
  assign dram_misalign = sram_en && misalign;

  assign dram_data_ok  = (state == S_READ) && !dram_flush && !rst;
  assign dram_rdata    = rd_misalign ? '0 : sram_rdata;

endmodule

`default_nettype wire

// File: tb/tb_dram_responder.sv
// tb_dram_responder -- directed bench with a cycle-level behavioural model for WAIT_CYCLES=0 and 3.
`default_nettype none

module tb_dram_responder;
  import dram_responder_pkg::*;

  localparam int NI = 2;
  localparam int AW = 12;
  localparam int W1 = 3;
`ifdef DRAM_MISALIGN_CHECK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0]        rst, req, wr, flush;
  logic [NI-1:0][2:0]   op;
  logic [NI-1:0][31:0]  addr, wdata;
  logic [NI-1:0]        addr_ok, data_ok, misal, sram_en;
  logic [NI-1:0][3:0]   sram_we;
  logic [NI-1:0][AW-1:0] sram_addr;
  logic [NI-1:0][31:0]  rdata, sram_wdata;

  int n_cmp = 0;
  int n_bad = 0;

  for (genvar g = 0; g < NI; g++) begin : g_inst
    logic [31:0] srd;
    logic [31:0] smem [4096];

    dram_responder #(.WAIT_CYCLES((g == 0) ? 0 : W1), .SRAM_AW(AW)) dut (
      .clk          (clk),
      .rst          (rst[g]),
      .dram_req     (req[g]),
      .dram_write   (wr[g]),
      .dram_opcode  (op[g]),
      .dram_addr    (addr[g]),
      .dram_wdata   (wdata[g]),
      .dram_flush   (flush[g]),
      .dram_addr_ok (addr_ok[g]),
      .dram_data_ok (data_ok[g]),
      .dram_rdata   (rdata[g]),
      .dram_misalign(misal[g]),
      .sram_en      (sram_en[g]),
      .sram_we      (sram_we[g]),
      .sram_addr    (sram_addr[g]),
      .sram_wdata   (sram_wdata[g]),
      .sram_rdata   (srd)
    );

    initial begin
      for (int k = 0; k < 4096; k++) smem[k] = '0;
    end

    always @(posedge clk) begin
      if (sram_en[g]) begin
        srd <= smem[sram_addr[g]];
        for (int b = 0; b < 4; b++)
          if (sram_we[g][b]) smem[sram_addr[g]][8*b +: 8] <= sram_wdata[g][8*b +: 8];
      end
    end
  end

  task automatic check(string nm, int inst, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s inst%0d t=%0t got=%h exp=%h", nm, inst, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int cyc = 0;
  logic [NI-1:0]       pend_v, pend_w;
  logic [NI-1:0][2:0]  pend_op;
  logic [NI-1:0][31:0] pend_a, pend_d, exp_rd;
  int pend_t [NI];
  int free_at [NI];
  int rd_due [NI];
  logic [31:0] emem [NI][4096];

  function automatic int wc(int i);
    return (i == 0) ? 0 : W1;
  endfunction

  task automatic model_step(int i);
    bit e_ok, e_dok, e_en, e_mis, chk_wd, do_acc, mis;
    logic [3:0]  e_we, strb;
    logic [AW-1:0] e_addr;
    logic [31:0] e_wd, e_rd, a, d, rep;
    logic [1:0]  lane;
    int w;
    w = wc(i);
    e_ok = 0; e_dok = 0; e_en = 0; e_mis = 0; chk_wd = 0; do_acc = 0; mis = 0;
    e_we = '0; strb = '0; e_addr = '0; e_wd = '0; e_rd = '0; rep = '0;
    if (rst[i]) begin
      pend_v[i] = 1'b0;
      rd_due[i] = -1;
      free_at[i] = cyc + 1;
    end else begin
      if (rd_due[i] == cyc) begin
        e_dok = !flush[i];
        e_rd = exp_rd[i];
        rd_due[i] = -1;
      end
      if (pend_v[i]) begin
        if (!pend_w[i] && flush[i]) begin
          pend_v[i] = 1'b0;
          free_at[i] = cyc + 1;
        end else if (cyc == pend_t[i] + w) begin
          do_acc = 1;
        end
      end
      e_ok = (cyc >= free_at[i]) && !flush[i];
      if (e_ok && req[i]) begin
        pend_v[i] = 1'b1; pend_w[i] = wr[i]; pend_op[i] = op[i];
        pend_a[i] = addr[i]; pend_d[i] = wdata[i]; pend_t[i] = cyc;
        free_at[i] = cyc + w + (wr[i] ? 1 : 2);
        if (w == 0) do_acc = 1;
      end
      if (do_acc) begin
        a = pend_a[i]; d = pend_d[i]; lane = a[1:0];
        case (pend_op[i])
          MEM_OP_BYTE: begin strb = 4'(1 << lane); rep = {24'b0, d[7:0]} * 32'h0101_0101; mis = 0; end
          MEM_OP_HALF: begin strb = 4'(3 << (2 * lane[1])); rep = {16'b0, d[15:0]} * 32'h0001_0001; mis = MIS_EN && lane[0]; end
          default:     begin strb = 4'hF; rep = d; mis = MIS_EN && (lane != 2'd0); end
        endcase
        e_en = 1; e_mis = mis; e_addr = a[AW+1:2];
        if (pend_w[i]) begin
          e_we = mis ? 4'h0 : strb;
          e_wd = rep;
          chk_wd = (e_we != 0);
          for (int b = 0; b < 4; b++)
            if (e_we[b]) emem[i][e_addr][8*b +: 8] = rep[8*b +: 8];
        end else begin
          exp_rd[i] = mis ? 32'h0 : emem[i][e_addr];
          rd_due[i] = cyc + 1;
        end
        pend_v[i] = 1'b0;
      end
    end
    check("addr_ok", i, addr_ok[i], e_ok);
    check("data_ok", i, data_ok[i], e_dok);
    check("sram_en", i, sram_en[i], e_en);
    check("sram_we", i, sram_we[i], e_we);
    check("misalign", i, misal[i], e_mis);
    if (e_en) check("sram_addr", i, sram_addr[i], e_addr);
    if (chk_wd) check("sram_wdata", i, sram_wdata[i], e_wd);
    if (e_dok) check("rdata", i, rdata[i], e_rd);
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) model_step(i);
    cyc++;
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(int i, logic w, logic [2:0] o, logic [31:0] a, logic [31:0] d);
    req[i] = 1'b1; wr[i] = w; op[i] = o; addr[i] = a; wdata[i] = d;
  endtask

  task automatic idle(int i);
    req[i] = 1'b0; flush[i] = 1'b0;
  endtask

  // Caller sets up the request for step 0; records per-step outputs, optional flush at step fl_at.
  task automatic trace(int i, int nk, int fl_at, output logic [7:0] en_v, output logic [7:0] ok_v,
                       output logic [7:0] dok_v, output logic [31:0] rd_v);
    en_v = '0; ok_v = '0; dok_v = '0; rd_v = 32'hFFFF_FFFF;
    for (int k = 0; k < nk; k++) begin
      flush[i] = (k == fl_at);
      #2;
      en_v[k] = sram_en[i]; ok_v[k] = addr_ok[i]; dok_v[k] = data_ok[i];
      if (data_ok[i]) rd_v = rdata[i];
      tick();
      req[i] = 1'b0; flush[i] = 1'b0;
    end
  endtask

  initial begin
    logic [7:0]  ev, ov, dv;
    logic [31:0] rv;
    int acc;
    for (int i = 0; i < NI; i++) begin
      pend_v[i] = 0; pend_w[i] = 0; pend_op[i] = '0; pend_a[i] = '0; pend_d[i] = '0;
      exp_rd[i] = '0; pend_t[i] = 0; free_at[i] = 0; rd_due[i] = -1;
      for (int k = 0; k < 4096; k++) emem[i][k] = '0;
    end
    rst = '1; req = '0; wr = '0; flush = '0; op = {NI{MEM_OP_WORD}}; addr = '0; wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = '0;
    #2;
    check("post_rst_ok", 0, addr_ok[0], 1'b1);
    check("post_rst_ok", 1, addr_ok[1], 1'b1);
    tick();

    // ---- WAIT_CYCLES = 0 ----
    set_req(0, 1, MEM_OP_BYTE, 32'h13, 32'hFFFF_FFA5); #2;
    check("stb_en", 0, sram_en[0], 1'b1);
    check("stb_we", 0, sram_we[0], 4'b1000);
    check("stb_wd", 0, sram_wdata[0], 32'hA5A5_A5A5);
    tick();
    set_req(0, 0, MEM_OP_WORD, 32'h10, 32'h0); #2;
    check("ld_ok", 0, addr_ok[0], 1'b1);
    tick(); idle(0); #2;
    check("ld_dok", 0, data_ok[0], 1'b1);
    check("ld_byte_rd", 0, rdata[0], 32'hA500_0000);
    tick();

    set_req(0, 1, MEM_OP_WORD, 32'h10, 32'hDEAD_BEEF); #2;
    check("stw_we", 0, sram_we[0], 4'hF);
    tick();
    set_req(0, 0, MEM_OP_WORD, 32'h10, 32'h0);
    tick(); idle(0); #2;
    check("ldw_rd", 0, rdata[0], 32'hDEAD_BEEF);
    tick();

    set_req(0, 1, MEM_OP_HALF, 32'h11, 32'h0000_1234); #2;
    check("sth_odd_we", 0, sram_we[0], MIS_EN ? 4'b0000 : 4'b0011);
    check("sth_odd_mis", 0, misal[0], MIS_EN);
    tick();
    set_req(0, 0, MEM_OP_WORD, 32'h10, 32'h0);
    tick(); idle(0); #2;
    check("sth_odd_rd", 0, rdata[0], MIS_EN ? 32'hDEAD_BEEF : 32'hDEAD_1234);
    tick();

    set_req(0, 1, MEM_OP_HALF, 32'h22, 32'h0000_BEEF); #2;
    check("sth_hi_we", 0, sram_we[0], 4'b1100);
    check("sth_hi_wd", 0, sram_wdata[0], 32'hBEEF_BEEF);
    tick(); idle(0);

    acc = 0;
    set_req(0, 0, MEM_OP_WORD, 32'h20, 32'h0);
    repeat (6) begin
      #2; acc += int'(addr_ok[0] && req[0]);
      tick();
    end
    idle(0);
    check("b2b_loads", 0, acc, 3);
    tick();

    acc = 0;
    for (int k = 0; k < 4; k++) begin
      set_req(0, 1, MEM_OP_WORD, 32'h40 + 4 * k, k + 1);
      #2; acc += int'(addr_ok[0]);
      tick();
    end
    idle(0);
    check("b2b_stores", 0, acc, 4);
    set_req(0, 0, MEM_OP_WORD, 32'h48, 32'h0);
    tick(); idle(0); #2;
    check("b2b_st_rd", 0, rdata[0], 32'h3);
    tick();

    set_req(0, 0, MEM_OP_WORD, 32'h10, 32'h0); flush[0] = 1'b1; #2;
    check("flush_idle_ok", 0, addr_ok[0], 1'b0);
    check("flush_idle_en", 0, sram_en[0], 1'b0);
    tick(); idle(0);

    set_req(0, 0, MEM_OP_WORD, 32'h10, 32'h0);
    tick(); idle(0); rst[0] = 1'b1; #2;
    check("rst_ld_dok", 0, data_ok[0], 1'b0);
    tick(); rst[0] = 1'b0; #2;
    check("rst_ld_ok", 0, addr_ok[0], 1'b1);
    tick();

    // ---- WAIT_CYCLES = 3 ----
    set_req(1, 1, MEM_OP_WORD, 32'h10, 32'h1122_3344);
    trace(1, 6, -1, ev, ov, dv, rv);
    check("w3_st_en", 1, ev, 8'b0000_1000);
    check("w3_st_ok", 1, ov, 8'b0011_0001);

    set_req(1, 0, MEM_OP_WORD, 32'h10, 32'h0);
    trace(1, 7, -1, ev, ov, dv, rv);
    check("w3_ld_en", 1, ev, 8'b0000_1000);
    check("w3_ld_ok", 1, ov, 8'b0110_0001);
    check("w3_ld_dok", 1, dv, 8'b0001_0000);
    check("w3_ld_rd", 1, rv, 32'h1122_3344);

    set_req(1, 0, MEM_OP_WORD, 32'h10, 32'h0);
    trace(1, 6, 2, ev, ov, dv, rv);
    check("w3_flld_en", 1, ev, 8'b0000_0000);
    check("w3_flld_dok", 1, dv, 8'b0000_0000);
    check("w3_flld_ok", 1, ov, 8'b0011_1001);

    set_req(1, 1, MEM_OP_WORD, 32'h10, 32'h5566_7788);
    trace(1, 6, 2, ev, ov, dv, rv);
    check("w3_flst_en", 1, ev, 8'b0000_1000);
    check("w3_flst_ok", 1, ov, 8'b0011_0001);

    set_req(1, 0, MEM_OP_WORD, 32'h10, 32'h0);
    trace(1, 6, -1, ev, ov, dv, rv);
    check("w3_flst_rd", 1, rv, 32'h5566_7788);

    set_req(1, 1, MEM_OP_WORD, 32'h10, 32'h0000_0099);
    tick(); idle(1); rst[1] = 1'b1; #2;
    check("w3_rst_en", 1, sram_en[1], 1'b0);
    tick(); rst[1] = 1'b0; #2;
    check("w3_rst_ok", 1, addr_ok[1], 1'b1);
    tick();

    set_req(1, 0, MEM_OP_WORD, 32'h10, 32'h0);
    trace(1, 6, -1, ev, ov, dv, rv);
    check("w3_drop_rd", 1, rv, 32'h5566_7788);

    set_req(1, 0, MEM_OP_WORD, 32'h12, 32'h0);
    trace(1, 6, -1, ev, ov, dv, rv);
    check("w3_mis_dok", 1, dv, 8'b0001_0000);
    check("w3_mis_rd", 1, rv, MIS_EN ? 32'h0 : 32'h5566_7788);

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
